// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single mainMem port between the fetch (i_*) and
// load/store (d_*) requesters, running each access as a 1/4/8/16-beat burst
// with mem_en high for exactly the burst length, then one mem_en-low
// RECOVER cycle so the memory's internal burst counter clears.
// Ports: clk/rst (async active-high); i_req/i_addr/i_acc_size in and
// i_gnt/i_rdata/i_valid/i_done out for fetch; d_req/d_wren/d_addr/d_wdata/
// d_acc_size in and d_gnt/d_rdata/d_valid/d_done out for load/store;
// mem_addr/mem_d_in/mem_acc_size/mem_wren/mem_en out and mem_d_out/mem_busy in.
// Build option MEM_ARB_FIXED_PRIO_EN: data port always wins ties (fetch can
// starve); default build is round-robin.
module mem_arbiter #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int ACCESS_SIZE  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDRESS_SIZE-1:0] i_addr,
  input  logic [ACCESS_SIZE-1:0]  i_acc_size,
  output logic                    i_gnt,
  output logic [DATA_SIZE-1:0]    i_rdata,
  output logic                    i_valid,
  output logic                    i_done,
  input  logic                    d_req,
  input  logic                    d_wren,
  input  logic [ADDRESS_SIZE-1:0] d_addr,
  input  logic [DATA_SIZE-1:0]    d_wdata,
  input  logic [ACCESS_SIZE-1:0]  d_acc_size,
  output logic                    d_gnt,
  output logic [DATA_SIZE-1:0]    d_rdata,
  output logic                    d_valid,
  output logic                    d_done,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0]    mem_d_in,
  input  logic [DATA_SIZE-1:0]    mem_d_out,
  output logic [ACCESS_SIZE-1:0]  mem_acc_size,
  output logic                    mem_wren,
  output logic                    mem_en,
  input  logic                    mem_busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BURST   = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;

  logic [1:0] state;
  logic [4:0] beat;       // beat index within the current burst
  logic [4:0] last_beat;  // B-1 of the current burst
  logic       owner_d;    // 1 = data port owns the current burst
  logic       last_d;     // most recent winner, 1 = data, 0 = fetch

  // Busy is informational only; beat count sequences the burst.
  logic busy_unused;
  assign busy_unused = mem_busy;

  function automatic logic [4:0] last_beat_of(input logic [ACCESS_SIZE-1:0] code);
    case (code[1:0])
      2'b00:   last_beat_of = 5'd0;
      2'b01:   last_beat_of = 5'd3;
      2'b10:   last_beat_of = 5'd7;
      default: last_beat_of = 5'd15;
    endcase
  endfunction

  // Arbitration, used only when leaving IDLE or RECOVER.
  logic grant_any, grant_d;
  assign grant_any = i_req | d_req;
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign grant_d = d_req;
`else
  // Tie goes to whichever port did not win last time.
  assign grant_d = d_req & (~i_req | ~last_d);
`endif

  // Winner's request fields; stores are forced to a single beat.
  logic                    sel_wren;
  logic [ACCESS_SIZE-1:0]  sel_acc;
  logic [ADDRESS_SIZE-1:0] sel_addr;
  logic [4:0]              sel_last;
  assign sel_wren = grant_d & d_wren;
  assign sel_acc  = grant_d ? (d_wren ? '0 : d_acc_size) : i_acc_size;
  assign sel_addr = grant_d ? d_addr : i_addr;
  assign sel_last = last_beat_of(sel_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      beat         <= '0;
      last_beat    <= '0;
      owner_d      <= 1'b0;
      last_d       <= 1'b0;
      mem_addr     <= '0;
      mem_d_in     <= '0;
      mem_acc_size <= '0;
      mem_wren     <= 1'b0;
      mem_en       <= 1'b0;
      i_gnt        <= 1'b0;
      d_gnt        <= 1'b0;
      i_valid      <= 1'b0;
      d_valid      <= 1'b0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_RECOVER: begin
          if (grant_any) begin
            state        <= S_BURST;
            beat         <= '0;
            last_beat    <= sel_last;
            owner_d      <= grant_d;
            last_d       <= grant_d;
            mem_addr     <= sel_addr;
            mem_acc_size <= sel_acc;
            mem_wren     <= sel_wren;
            mem_d_in     <= sel_wren ? d_wdata : '0;
            mem_en       <= 1'b1;
            i_gnt        <= ~grant_d;
            d_gnt        <= grant_d;
            i_valid      <= ~grant_d;
            d_valid      <= grant_d;
            // Single-beat bursts are done on their first (only) beat.
            i_done       <= ~grant_d & (sel_last == 5'd0);
            d_done       <= grant_d & (sel_last == 5'd0);
          end else begin
            state <= S_IDLE;
          end
        end
        S_BURST: begin
          beat <= beat + 5'd1;
          if (beat == last_beat) begin
            state    <= S_RECOVER;
            mem_en   <= 1'b0;
            mem_wren <= 1'b0;
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_valid  <= 1'b0;
            d_valid  <= 1'b0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
          end else begin
            // done is registered, so flag it one beat ahead of the last one.
            i_done <= ~owner_d & (beat + 5'd1 == last_beat);
            d_done <= owner_d & (beat + 5'd1 == last_beat);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data passes straight through, gated to the owning port.
  assign i_rdata = i_valid ? mem_d_out : '0;
  assign d_rdata = (d_valid & ~mem_wren) ? mem_d_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small burst-capable memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wren;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  i_acc_size, d_acc_size;
  logic        i_gnt, i_valid, i_done, d_gnt, d_valid, d_done;
  logic [31:0] i_rdata, d_rdata;
  logic [31:0] mem_addr, mem_d_in, mem_d_out;
  logic [1:0]  mem_acc_size;
  logic        mem_wren, mem_en, mem_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_acc_size(i_acc_size),
    .i_gnt(i_gnt), .i_rdata(i_rdata), .i_valid(i_valid), .i_done(i_done),
    .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_acc_size(d_acc_size), .d_gnt(d_gnt), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_done(d_done),
    .mem_addr(mem_addr), .mem_d_in(mem_d_in), .mem_d_out(mem_d_out),
    .mem_acc_size(mem_acc_size), .mem_wren(mem_wren), .mem_en(mem_en),
    .mem_busy(mem_busy)
  );

  // Memory model: 64 words, internal burst counter cleared while en is low.
  logic [31:0] mem [0:63];
  logic [5:0]  bcnt = '0;
  logic [5:0]  idx;
  assign idx      = mem_addr[7:2] + bcnt;
  assign mem_busy = mem_en;
  always_comb mem_d_out = mem_en ? mem[idx] : 32'h0;
  always @(posedge clk) begin
    if (mem_en && mem_wren) mem[idx] <= mem_d_in;
    if (mem_en) bcnt <= bcnt + 6'd1;
    else        bcnt <= '0;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] w);
    d_req = 1'b1; d_wren = 1'b1; d_addr = a; d_wdata = w;
    d_acc_size = 2'b11;  // ignored for stores
    tick;
    for (int n = 0; n < 40 && !d_done; n++) tick;
    chk("store_done", {31'b0, d_done}, 32'd1);
    chk("store_acc", {30'b0, mem_acc_size}, 32'd0);
    d_req = 1'b0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words [0:3];
    int cnt, other;
    logic exp_d;
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;

    // Reset with both ports already requesting: store vs single-word fetch.
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h80020000; i_acc_size = 2'b00;
    d_req = 1'b1; d_wren = 1'b1; d_addr = 32'h80020000;
    d_wdata = 32'hDEADBEEF; d_acc_size = 2'b00;
    repeat (3) tick;
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_gnts", {30'b0, i_gnt, d_gnt}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_dones", {28'b0, i_done, d_done, i_valid, d_valid}, 32'd0);
    rst = 1'b0;
    tick;
    chk("t1_d_gnt", {30'b0, d_gnt, i_gnt}, 32'd2);
    chk("t1_wren_en", {30'b0, mem_wren, mem_en}, 32'd3);
    chk("t1_addr", mem_addr, 32'h80020000);
    chk("t1_wdata", mem_d_in, 32'hDEADBEEF);
    chk("t1_d_done", {30'b0, d_valid, d_done}, 32'd3);
    d_req = 1'b0;
    tick;
    chk("t1_recover_en", {31'b0, mem_en}, 32'd0);
    chk("t1_recover_gnt", {30'b0, d_gnt, i_gnt}, 32'd0);
    tick;
    chk("t1_i_gnt", {30'b0, i_gnt, d_gnt}, 32'd2);
    chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("t1_i_done", {31'b0, i_done}, 32'd1);
    chk("t1_d_rdata", d_rdata, 32'd0);
    i_req = 1'b0;
    tick;
    chk("t1_i_recover", {31'b0, mem_en}, 32'd0);
    tick;

    // Preload four words through the store path.
    for (int k = 0; k < 4; k++) do_store(32'h80020000 + 32'(k * 4), words[k]);

    // Four-beat fetch.
    i_req = 1'b1; i_addr = 32'h80020000; i_acc_size = 2'b01;
    tick;
    for (int b = 0; b < 4; b++) begin
      chk("t2_valid", {31'b0, i_valid}, 32'd1);
      chk("t2_rdata", i_rdata, words[b]);
      chk("t2_done", {31'b0, i_done}, (b == 3) ? 32'd1 : 32'd0);
      if (b < 3) tick;
    end
    i_req = 1'b0;
    tick;
    chk("t2_en_low", {30'b0, mem_en, i_valid}, 32'd0);
    tick;

    // Fields changed mid-burst are ignored.
    i_req = 1'b1; i_addr = 32'h80020004; i_acc_size = 2'b01;
    tick;
    chk("t5_beat0", i_rdata, words[1]);
    i_addr = 32'h80020000; i_acc_size = 2'b11;
    for (int b = 1; b < 4; b++) begin
      tick;
      chk("t5_addr", mem_addr, 32'h80020004);
      chk("t5_acc", {30'b0, mem_acc_size}, 32'd1);
      chk("t5_done", {31'b0, i_done}, (b == 3) ? 32'd1 : 32'd0);
      if (b < 3) chk("t5_rdata", i_rdata, words[b + 1]);
    end
    i_req = 1'b0;
    tick;
    chk("t5_en_low", {31'b0, mem_en}, 32'd0);
    tick;
    tick;

    // Both ports continuously request 16-beat loads.
    i_req = 1'b1; i_addr = 32'h80020000; i_acc_size = 2'b11;
    d_req = 1'b1; d_wren = 1'b0; d_addr = 32'h80020000; d_acc_size = 2'b11;
    tick;
    chk("t3_first_d_rdata", d_rdata, words[0]);
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_d = 1'b1;
`else
      exp_d = (k % 2 == 0);
`endif
      cnt = 0; other = 0;
      for (int j = 0; j < 16; j++) begin
        if ((exp_d ? d_gnt : i_gnt) && mem_en) cnt++;
        if (exp_d ? i_gnt : d_gnt) other++;
        if (j == 15) chk("t3_done", {31'b0, exp_d ? d_done : i_done}, 32'd1);
        else tick;
      end
      chk("t3_beats", 32'(cnt), 32'd16);
      chk("t3_other_gnt", 32'(other), 32'd0);
      tick;
      chk("t3_recover_en", {31'b0, mem_en}, 32'd0);
      if (k < 3) tick;
    end

    // Reset on beat 5 of a 16-beat fetch.
    d_req = 1'b0;
    tick;
    chk("t4_i_gnt", {31'b0, i_gnt}, 32'd1);
    repeat (4) tick;
    chk("t4_beat5_en", {31'b0, mem_en}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t4_async_en", {31'b0, mem_en}, 32'd0);
    chk("t4_async_gnt", {29'b0, i_gnt, i_valid, i_done}, 32'd0);
    chk("t4_async_rdata", i_rdata, 32'd0);
    d_req = 1'b1; d_wren = 1'b0; d_addr = 32'h80020008; d_acc_size = 2'b00;
    tick;
    rst = 1'b0;
    tick;
    chk("t4_tie_d_gnt", {30'b0, d_gnt, i_gnt}, 32'd2);
    chk("t4_d_rdata", d_rdata, words[2]);
    chk("t4_d_done", {31'b0, d_done}, 32'd1);
    d_req = 1'b0; i_req = 1'b0;
    tick;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
